// File: rtl/sram_req_ctrl.sv
// sram_req_ctrl
//   Front-end controller for a single-port OpenRAM SRAM macro. It fills the
//   whole array with INIT_VALUE after reset, then turns a valid/ready request
//   stream into registered, active-low macro port cycles. Read data is
//   captured into a response FIFO that is credit-protected, so it can never
//   overflow.
//
// Handshakes (both streams): a transfer happens at the posedge where valid
// and ready are both high. The producer holds valid and its payload until
// that edge. req_ready is a function of registered state only, so it never
// depends combinationally on req_valid.
//
// Ports
//   clk0, rst0            clock shared with the macro; async active-high reset
//   req_valid/req_ready   request handshake
//   req_we                1 = write, 0 = read
//   req_addr, req_wdata   word address and write data
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata             read data in request order (registered head entry)
//   init_done             fill complete, stays high until reset
//   csb0, web0            macro chip select / write enable, active low
//   ADDR0, DIN0, DOUT0    macro address, write data, read data
module sram_req_ctrl #(
  parameter int DATA_WIDTH = 2,
  parameter int ADDR_WIDTH = 4,
  parameter int RSP_DEPTH  = 4,
  parameter int INIT_EN    = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  init_done,
  output logic                  csb0,
  output logic                  web0,
  output logic [ADDR_WIDTH-1:0] ADDR0,
  output logic [DATA_WIDTH-1:0] DIN0,
  input  logic [DATA_WIDTH-1:0] DOUT0
);

  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(RSP_DEPTH);
  localparam bit DO_FILL = (INIT_EN != 0);

  typedef enum logic {ST_INIT, ST_RUN} state_t;
  state_t state, state_next;

  logic [ADDR_WIDTH-1:0] fill_cnt;
  logic                  fill_last_issued;  // final fill write already registered
  logic [1:0]            rd_pipe;           // [0]: issued last edge, [1]: macro read this cycle

  logic [DATA_WIDTH-1:0] fifo_mem [RSP_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr, rd_ptr_next;
  logic [CW-1:0]         rsp_count, count_next;
  logic [CW:0]           credit_used;

  logic accept, rd_accept, push, pop;

  // Credits cover FIFO occupancy plus reads still travelling through the
  // macro; all terms are registered, so a pop frees its credit one cycle later.
  assign credit_used = {1'b0, rsp_count} + {{CW{1'b0}}, rd_pipe[0]} + {{CW{1'b0}}, rd_pipe[1]};
  assign req_ready   = (state == ST_RUN) && (credit_used < DEPTH_C);
  assign accept      = req_valid && req_ready;
  assign rd_accept   = accept && !req_we;
  assign push        = rd_pipe[1];
  assign rsp_valid   = (rsp_count != '0);
  assign pop         = rsp_valid && rsp_ready;

  // State register
  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) state <= ST_INIT;
    else      state <= state_next;
  end

  // Next state
  always_comb begin
    state_next = state;
    case (state)
      ST_INIT: if (!DO_FILL || fill_last_issued) state_next = ST_RUN;
      ST_RUN:  state_next = ST_RUN;
      default: state_next = ST_INIT;
    endcase
  end

  // Macro port, fill counter and read-capture pipeline
  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      csb0             <= 1'b1;
      web0             <= 1'b1;
      ADDR0            <= '0;
      DIN0             <= '0;
      init_done        <= 1'b0;
      fill_cnt         <= '0;
      fill_last_issued <= 1'b0;
      rd_pipe          <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          rd_pipe <= '0;
          if (DO_FILL && !fill_last_issued) begin
            csb0  <= 1'b0;
            web0  <= 1'b0;
            ADDR0 <= fill_cnt;
            DIN0  <= INIT_VALUE;
            // The counter parks on the last address instead of wrapping.
            if (fill_cnt == {ADDR_WIDTH{1'b1}}) fill_last_issued <= 1'b1;
            else                                fill_cnt <= fill_cnt + ADDR_WIDTH'(1);
          end else begin
            csb0      <= 1'b1;
            web0      <= 1'b1;
            init_done <= 1'b1;
          end
        end
        default: begin
          rd_pipe <= {rd_pipe[0], rd_accept};
          if (accept) begin
            csb0  <= 1'b0;
            web0  <= !req_we;
            ADDR0 <= req_addr;
            DIN0  <= req_wdata;
          end else begin
            csb0  <= 1'b1;
            web0  <= 1'b1;
          end
        end
      endcase
    end
  end

  // Response FIFO bookkeeping
  always_comb begin
    rd_ptr_next = pop ? rd_ptr + PW'(1) : rd_ptr;
    count_next  = rsp_count;
    if (push && !pop)      count_next = rsp_count + CW'(1);
    else if (!push && pop) count_next = rsp_count - CW'(1);
  end

  always_ff @(posedge clk0) begin
    if (push) fifo_mem[wr_ptr] <= DOUT0;
  end

  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rsp_count <= '0;
      rsp_rdata <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      rd_ptr    <= rd_ptr_next;
      rsp_count <= count_next;
      // The new head is the word being pushed right now when it lands in an
      // otherwise empty FIFO; else it is already in storage. Empty: hold.
      if (push && count_next == CW'(1)) rsp_rdata <= DOUT0;
      else if (count_next != '0)        rsp_rdata <= fifo_mem[rd_ptr_next];
    end
  end

endmodule

// File: tb/tb_sram_req_ctrl.sv
// tb_sram_req_ctrl
//   Directed bench for sram_req_ctrl with a behavioural OpenRAM-style macro:
//   port signals are sampled at posedge, the write or read executes at the
//   following negedge, DOUT0 then holds until the next read.
module tb_sram_req_ctrl;
  localparam int DW = 2;
  localparam int AW = 4;
  localparam int RD = 4;

  logic          clk0 = 1'b0;
  logic          rst0 = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_rdata;
  logic          init_done;
  logic          csb0, web0;
  logic [AW-1:0] ADDR0;
  logic [DW-1:0] DIN0;
  logic [DW-1:0] DOUT0 = '0;

  int checks = 0;
  int errors = 0;

  // ---------------- clock ----------------
  always #5 clk0 = ~clk0;

  sram_req_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RSP_DEPTH(RD),
    .INIT_EN(1), .INIT_VALUE(2'b01)
  ) dut (
    .clk0(clk0), .rst0(rst0),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .init_done(init_done),
    .csb0(csb0), .web0(web0), .ADDR0(ADDR0), .DIN0(DIN0), .DOUT0(DOUT0)
  );

  // ---------------- macro model ----------------
  logic [DW-1:0] sram_mem [16];
  logic          s_csb = 1'b1;
  logic          s_web = 1'b1;
  logic [AW-1:0] s_addr = '0;
  logic [DW-1:0] s_din = '0;

  initial begin
    for (int i = 0; i < 16; i++) sram_mem[i] = 2'b11;
  end

  always @(posedge clk0) begin
    s_csb  <= csb0;
    s_web  <= web0;
    s_addr <= ADDR0;
    s_din  <= DIN0;
  end

  always @(negedge clk0) begin
    if (!s_csb) begin
      if (!s_web) sram_mem[s_addr] = s_din;
      else        DOUT0 <= sram_mem[s_addr];
    end
  end

  // ---------------- scoreboard ----------------
  logic [DW-1:0] ref_mem [16];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];
  int            got_cyc[$];
  int            cyc = 0;

  always @(posedge clk0) begin
    cyc <= cyc + 1;
    if (rsp_valid && rsp_ready) begin
      got_q.push_back(rsp_rdata);
      got_cyc.push_back(cyc);
    end
  end

  // ---------------- driver tasks ----------------
  // Called #1 after a posedge; returns #1 after the accepting edge with
  // req_valid still high so consecutive calls issue at full rate.
  task automatic drive_req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk0); #1;
      n++;
    end
    checks++;
    if (!req_ready) begin
      errors++;
      $display("FAIL req_accept_timeout: req_ready=%b required 1 (addr %0d)", req_ready, a);
    end
    @(posedge clk0); #1;
    if (we) ref_mem[a] = d;
    else    exp_q.push_back(ref_mem[a]);
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) begin
      @(posedge clk0); #1;
    end
  endtask

  task automatic collect(input int n);
    int i;
    i = 0;
    while (got_q.size() < n && i < 100) begin
      @(posedge clk0); #1;
      i++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    logic [13:0] obs;
    repeat (2) @(posedge clk0);
    #1;
    obs = {csb0, web0, ADDR0, DIN0, req_ready, rsp_valid, rsp_rdata, init_done};
    checks++;
    if (obs !== 14'b11_0000_00_0_0_00_0) begin
      errors++;
      $display("FAIL reset_values: got %b required %b", obs, 14'b11_0000_00_0_0_00_0);
    end
  endtask

  task automatic test_init_fill;
    logic [7:0] obs;
    logic [7:0] req;
    int bad;
    rst0 = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk0); #1;
      obs = {csb0, web0, ADDR0, DIN0};
      req = {1'b0, 1'b0, 4'(k), 2'b01};
      checks++;
      if (obs !== req) begin
        errors++;
        $display("FAIL init_write_%0d: csb/web/addr/din=%b required %b", k, obs, req);
      end
    end
    @(posedge clk0); #1;
    checks++;
    if ({csb0, web0, init_done, req_ready} !== 4'b1111) begin
      errors++;
      $display("FAIL init_end: csb0,web0,init_done,req_ready=%b required 1111",
               {csb0, web0, init_done, req_ready});
    end
    for (int i = 0; i < 16; i++) ref_mem[i] = 2'b01;
    idle(2);
    bad = 0;
    for (int i = 0; i < 16; i++) if (sram_mem[i] !== 2'b01) bad++;
    checks++;
    if (bad != 0 || init_done !== 1'b1) begin
      errors++;
      $display("FAIL init_contents: %0d words differ from 01, init_done=%b required 1", bad, init_done);
    end
    drive_req(1'b0, 4'd9, 2'b00);
    idle(1);
    collect(1);
    checks++;
    if (got_q.size() != 1 || exp_q.size() != 1) begin
      errors++;
      $display("FAIL init_read9_count: got %0d responses required 1", got_q.size());
    end else if (got_q[0] !== 2'b01) begin
      errors++;
      $display("FAIL init_read9: rsp_rdata=%b required 01", got_q[0]);
    end
    got_q.delete(); got_cyc.delete(); exp_q.delete();
  endtask

  task automatic test_read_after_write;
    drive_req(1'b1, 4'd3, 2'b10);
    drive_req(1'b0, 4'd3, 2'b00);
    req_valid = 1'b0;
    @(posedge clk0); #1;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL raw_latency_early: rsp_valid=%b required 0 one cycle after accept", rsp_valid);
    end
    @(posedge clk0); #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 2'b10) begin
      errors++;
      $display("FAIL raw_data: rsp_valid=%b rsp_rdata=%b required 1 and 10", rsp_valid, rsp_rdata);
    end
    collect(1);
    got_q.delete(); got_cyc.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++) drive_req(1'b1, 4'(i), 2'(i));
    for (int i = 0; i < 4; i++) drive_req(1'b0, 4'(i), 2'b00);
    idle(1);
    collect(4);
    checks++;
    if (got_q.size() != 4) begin
      errors++;
      $display("FAIL b2b_count: got %0d responses required 4", got_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got_q[i] !== 2'(i) || got_cyc[i] != got_cyc[0] + i) begin
          errors++;
          $display("FAIL b2b_rsp_%0d: data=%b cycle_offset=%0d required data=%b offset=%0d",
                   i, got_q[i], got_cyc[i] - got_cyc[0], 2'(i), i);
        end
      end
    end
    got_q.delete(); got_cyc.delete(); exp_q.delete();
  endtask

  task automatic test_backpressure;
    int ready_seen;
    logic [DW-1:0] e;
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) drive_req(1'b0, 4'(i), 2'b00);
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_credit_stop: req_ready=%b required 0 after 4 accepts", req_ready);
    end
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd4;
    ready_seen = 0;
    repeat (8) begin
      @(posedge clk0); #1;
      if (req_ready) ready_seen++;
    end
    checks++;
    if (ready_seen != 0 || rsp_valid !== 1'b1 || rsp_rdata !== 2'b00 || got_q.size() != 0) begin
      errors++;
      $display("FAIL bp_hold: ready_cycles=%0d rsp_valid=%b head=%b popped=%0d required 0,1,00,0",
               ready_seen, rsp_valid, rsp_rdata, got_q.size());
    end
    rsp_ready = 1'b1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_same_cycle_credit: req_ready=%b required 0", req_ready);
    end
    @(posedge clk0); #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_credit_return: req_ready=%b required 1", req_ready);
    end
    drive_req(1'b0, 4'd4, 2'b00);
    drive_req(1'b0, 4'd5, 2'b00);
    idle(1);
    collect(6);
    checks++;
    if (got_q.size() != 6) begin
      errors++;
      $display("FAIL bp_count: got %0d responses required 6", got_q.size());
    end
    for (int i = 0; i < 6; i++) begin
      if (got_q.size() > 0 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (got_q[0] !== e) begin
          errors++;
          $display("FAIL bp_order_%0d: rsp_rdata=%b required %b", i, got_q[0], e);
        end
        void'(got_q.pop_front());
      end
    end
    got_q.delete(); got_cyc.delete(); exp_q.delete();
  endtask

  task automatic test_reset_midflight;
    int n;
    int valid_seen;
    rsp_ready = 1'b0;
    drive_req(1'b0, 4'd5, 2'b00);
    idle(3);
    drive_req(1'b0, 4'd6, 2'b00);
    drive_req(1'b0, 4'd7, 2'b00);
    rst0 = 1'b1;
    req_valid = 1'b0;
    #1;
    checks++;
    if (csb0 !== 1'b1 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: csb0=%b rsp_valid=%b req_ready=%b required 1,0,0",
               csb0, rsp_valid, req_ready);
    end
    exp_q.delete(); got_q.delete(); got_cyc.delete();
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk0);
    #1;
    rst0 = 1'b0;
    @(posedge clk0); #1;
    checks++;
    if ({csb0, web0, ADDR0} !== 6'b00_0000) begin
      errors++;
      $display("FAIL refill_start: csb0,web0,ADDR0=%b required 000000", {csb0, web0, ADDR0});
    end
    n = 0;
    valid_seen = 0;
    while (!init_done && n < 40) begin
      @(posedge clk0); #1;
      if (rsp_valid) valid_seen++;
      n++;
    end
    for (int i = 0; i < 16; i++) ref_mem[i] = 2'b01;
    checks++;
    if (init_done !== 1'b1 || valid_seen != 0 || got_q.size() != 0) begin
      errors++;
      $display("FAIL refill_no_stale: init_done=%b valid_cycles=%0d responses=%0d required 1,0,0",
               init_done, valid_seen, got_q.size());
    end
    idle(1);
    drive_req(1'b0, 4'd6, 2'b00);
    idle(4);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 2'b01) begin
      errors++;
      $display("FAIL post_reset_read: responses=%0d first=%b required 1 response of 01",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 2'bxx);
    end
    got_q.delete(); got_cyc.delete(); exp_q.delete();
  endtask

  task automatic test_idle;
    logic [DW-1:0] e;
    drive_req(1'b1, 4'd7, 2'b10);
    req_valid = 1'b0; req_we = 1'b1; req_addr = 4'd8; req_wdata = 2'b11;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk0); #1;
      checks++;
      if (csb0 !== 1'b1 || web0 !== 1'b1) begin
        errors++;
        $display("FAIL idle_cycle_%0d: csb0=%b web0=%b required 1,1", i, csb0, web0);
      end
    end
    drive_req(1'b0, 4'd7, 2'b00);
    drive_req(1'b0, 4'd8, 2'b00);
    idle(1);
    collect(2);
    checks++;
    if (got_q.size() != 2) begin
      errors++;
      $display("FAIL idle_count: got %0d responses required 2", got_q.size());
    end
    for (int i = 0; i < 2; i++) begin
      if (got_q.size() > 0 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (got_q[0] !== e) begin
          errors++;
          $display("FAIL idle_readback_%0d: rsp_rdata=%b required %b", i, got_q[0], e);
        end
        void'(got_q.pop_front());
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_init_fill();
    test_read_after_write();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_req_ctrl.md
Name: sram_req_ctrl

Overview:
- Front-end controller directly upstream of a single-port OpenRAM SRAM macro (clk0/csb0/web0/ADDR0/DIN0/DOUT0 interface).
- Converts a valid/ready request stream into the macro's active-low port cycles.
- Fills the whole array with a known value after reset.
- Captures read data into a credit-protected response FIFO with valid/ready backpressure.

Parameters:
- DATA_WIDTH, 2, word width; must match the macro.
- ADDR_WIDTH, 4, address width; RAM_DEPTH = 1 << ADDR_WIDTH.
- RSP_DEPTH, 4, response FIFO entries; minimum 2, power of two.
- INIT_EN, 1, 1 = run the fill sequence after reset; 0 = go straight to RUN.
- INIT_VALUE, 0, word written to every address during fill.

Ports:
- clk0  in  1  clock, shared with the macro.
- rst0  in  1  asynchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready at posedge.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  consumer takes rsp_rdata at posedge when rsp_valid && rsp_ready.
- rsp_rdata  out  DATA_WIDTH  read data, in request order.
- init_done  out  1  fill complete; stays high until reset.
- csb0  out  1  macro chip select, active low.
- web0  out  1  macro write enable, active low.
- ADDR0  out  ADDR_WIDTH  macro address.
- DIN0  out  DATA_WIDTH  macro write data.
- DOUT0  in  DATA_WIDTH  macro read data.

Behaviour:
- Reset values (asynchronous): csb0=1, web0=1, ADDR0=0, DIN0=0, req_ready=0, rsp_valid=0, rsp_rdata=0, init_done=0.
- Reset also clears the FIFO, all counters and the in-flight pipeline. Reset mid-operation discards all pending reads; no response is emitted for them.
- FSM states: INIT, RUN.
  - After reset, the FSM enters INIT if INIT_EN=1, otherwise RUN with init_done=1 at the first edge.
- INIT:
  - Fill counter runs 0..RAM_DEPTH-1, one address per cycle.
  - Registered outputs per cycle: csb0=0, web0=0, ADDR0=counter, DIN0=INIT_VALUE.
  - Exactly RAM_DEPTH macro write cycles.
  - The edge after the last write sets csb0=1 and web0=1, sets init_done=1, and moves the FSM to RUN.
  - req_ready=0 throughout INIT.
- RUN:
  - req_ready = (rsp_count + rd_inflight < RSP_DEPTH).
    - rsp_count is the FIFO occupancy.
    - rd_inflight counts reads issued but not yet captured, range 0..2.
    - A pop in the same cycle does not free a credit until the next cycle.
  - On accept at posedge T:
    - csb0=0, web0=!req_we, ADDR0=req_addr, DIN0=req_wdata are registered at T.
    - The macro samples them at T+1.
  - No accept at T: csb0=1 and web0=1 from T; ADDR0/DIN0 hold.
  - Read issued at T: DOUT0 is captured into the FIFO at posedge T+2 (the macro's data is valid between its negedge and the following posedge). rsp_valid rises after T+2; accept-to-rsp_valid latency is 2 cycles.
  - Writes generate no response.
  - Back-to-back operations are allowed at full rate, one per cycle.
  - Read-after-write to the same address in consecutive cycles returns the new data: the macro write and read both complete at the negedge of their own cycle.
- Response FIFO:
  - rsp_rdata is the head entry, registered.
  - Push and pop in the same cycle keep occupancy unchanged.
  - Overflow cannot occur (credit rule); empty → rsp_valid=0 and rsp_rdata holds its last value.
- Pointers wrap modulo RSP_DEPTH. The fill counter stops at RAM_DEPTH-1 and does not wrap.

Test Plan:
- Reset, INIT_EN=1, INIT_VALUE=2'b01:
  - exactly 16 cycles with csb0=0, web0=0, ADDR0=0..15, DIN0=01;
  - then init_done=1 and req_ready=1;
  - a read of address 9 returns 01.
- RUN: write addr 3 = 2'b10, then read addr 3 in the next cycle → rsp_valid 2 cycles after the read is accepted, rsp_rdata=10.
- Back-to-back reads of addresses 0,1,2,3 after writing 00,01,10,11 with rsp_ready=1 → four consecutive rsp_valid cycles with data 00,01,10,11 in order.
- rsp_ready=0, issue 6 reads (RSP_DEPTH=4):
  - req_ready drops after 4 accepts; rsp_count=4 and no data is lost;
  - after raising rsp_ready, all 4 responses drain in order;
  - the remaining 2 reads are accepted only after credits return.
- Assert rst0 with 2 reads in flight and 1 response queued:
  - csb0=1 and rsp_valid=0 immediately (asynchronously);
  - the fill sequence restarts at ADDR0=0;
  - no stale responses appear.
- Idle cycles between requests → csb0=1 and web0=1 in every idle cycle; the macro memory is unchanged (verified by read-back).
